// File: rtl/regbank_arbiter_if.sv
// Host, core and bank signal bundle for the register bank arbiter.
// master drives requests and bank read data; slave is the arbiter.
interface regbank_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 8
);
  logic          h_req;
  logic          h_we;
  logic          h_lock;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;

  logic          c_req;
  logic [AW-1:0] c_addr;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] bank_rdata;

  modport master (
    output h_req, h_we, h_lock, h_addr, h_wdata,
    output c_req, c_addr, bank_rdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  bank_we, bank_addr, bank_wdata
  );

  modport slave (
    input  h_req, h_we, h_lock, h_addr, h_wdata,
    input  c_req, c_addr, bank_rdata,
    output h_gnt, h_rvalid, h_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output bank_we, bank_addr, bank_wdata
  );
endinterface

// File: rtl/regbank_arbiter.sv
// Round-robin host/core arbiter for the single-port register bank.
// REGBANK_ARB_STATS_EN adds saturating per-side wait counters.
module regbank_arbiter #(
  parameter int size_word = 8,
  parameter int nreg      = 122,
  parameter int max_burst = 121,
  localparam int AW = $clog2(nreg),
  localparam int CW = $clog2(max_burst + 1)
) (
  input  logic clk,
  input  logic rst,
  regbank_arbiter_if.slave bus
`ifdef REGBANK_ARB_STATS_EN
  ,
  output logic [15:0] h_wait_cnt,
  output logic [15:0] c_wait_cnt
`endif
);

  typedef enum logic {ARB, LOCK} state_t;
  typedef enum logic {WIN_HOST, WIN_CORE} win_t;

  state_t         state;
  win_t           last_win;
  logic [CW-1:0]  burst_cnt;
  logic           h_rv;
  logic           c_rv;
  logic [size_word-1:0] h_rd;
  logic [size_word-1:0] c_rd;

  logic hg;
  logic cg;
  logic forced;
  logic h_in;
  logic c_in;
  logic cnt_max;
  logic locked;

  assign h_in    = int'(bus.h_addr) < nreg;
  assign c_in    = int'(bus.c_addr) < nreg;
  assign cnt_max = burst_cnt == CW'(max_burst);
  assign locked  = (state == LOCK) && bus.h_lock;

  always_comb begin
    hg     = 1'b0;
    cg     = 1'b0;
    forced = 1'b0;
    if (!rst) begin
      if (locked) begin
        if (cnt_max && bus.c_req) begin
          cg     = 1'b1;
          forced = 1'b1;
        end else if (bus.h_req) begin
          hg = 1'b1;
        end else begin
          cg = bus.c_req;
        end
      end else begin
        unique case (1'b1)
          bus.h_req && !bus.c_req: hg = 1'b1;
          bus.c_req && !bus.h_req: cg = 1'b1;
          bus.h_req && bus.c_req: begin
            hg = last_win == WIN_CORE;
            cg = last_win == WIN_HOST;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.h_gnt = hg;
  assign bus.c_gnt = cg;

  assign bus.bank_we    = hg && bus.h_we && h_in;
  assign bus.bank_addr  = hg ? bus.h_addr
                        : cg ? bus.c_addr
                        : '0;
  assign bus.bank_wdata = hg ? bus.h_wdata : '0;

  // Reset masks a read-valid already captured on the preceding edge.
  assign bus.h_rvalid = h_rv && !rst;
  assign bus.c_rvalid = c_rv && !rst;
  assign bus.h_rdata  = h_rd;
  assign bus.c_rdata  = c_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      last_win  <= WIN_CORE;
      burst_cnt <= '0;
      h_rv      <= 1'b0;
      c_rv      <= 1'b0;
      h_rd      <= '0;
      c_rd      <= '0;
    end else begin
      h_rv <= hg && !bus.h_we;
      c_rv <= cg;
      if (hg && !bus.h_we)
        h_rd <= h_in ? bus.bank_rdata : '0;
      if (cg)
        c_rd <= c_in ? bus.bank_rdata : '0;
      if (hg)
        last_win <= WIN_HOST;
      else if (cg)
        last_win <= WIN_CORE;
      if (locked) begin
        if (forced)
          burst_cnt <= '0;
        else if (hg && !cnt_max)
          burst_cnt <= burst_cnt + 1'b1;
      end else if (hg && bus.h_lock) begin
        state     <= LOCK;
        burst_cnt <= CW'(1);
      end else begin
        state     <= ARB;
        burst_cnt <= '0;
      end
    end
  end

`ifdef REGBANK_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      h_wait_cnt <= '0;
      c_wait_cnt <= '0;
    end else begin
      if (bus.h_req && !hg && h_wait_cnt != 16'hFFFF)
        h_wait_cnt <= h_wait_cnt + 16'd1;
      if (bus.c_req && !cg && c_wait_cnt != 16'hFFFF)
        c_wait_cnt <= c_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regbank_arbiter.sv
// Randomized self-checking bench for regbank_arbiter.
// Reference model tracks lock/burst/round-robin and a shadow bank.
module tb_regbank_arbiter;
`ifdef REGBANK_ARB_STATS_EN
  localparam int MB = 4;
`else
  localparam int MB = 121;
`endif
  localparam int NREG = 122;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regbank_arbiter_if #(.AW(7), .DW(8)) bus ();

`ifdef REGBANK_ARB_STATS_EN
  logic [15:0] h_wait_cnt;
  logic [15:0] c_wait_cnt;
`endif

  regbank_arbiter #(
    .size_word(8),
    .nreg(NREG),
    .max_burst(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef REGBANK_ARB_STATS_EN
    ,
    .h_wait_cnt(h_wait_cnt),
    .c_wait_cnt(c_wait_cnt)
`endif
  );

  logic [7:0] mem [128];
  logic       load = 1'b0;
  logic [6:0] load_addr = '0;
  logic [7:0] load_data = '0;

  always @(posedge clk)
    if (load) mem[load_addr] <= load_data;
    else if (bus.bank_we) mem[bus.bank_addr] <= bus.bank_wdata;

  assign bus.bank_rdata = mem[bus.bank_addr];

  logic [7:0] ref_mem [128];
  bit   m_lock;
  bit   m_hlast;
  int   m_cnt;
  int   m_hwait;
  int   m_cwait;
  bit   exp_hv;
  bit   exp_cv;
  logic [7:0] exp_hrd;
  logic [7:0] exp_crd;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic drive(input bit hr, input bit we, input bit lk,
                       input logic [6:0] ha, input logic [7:0] hd,
                       input bit cr, input logic [6:0] ca);
    bus.h_req   = hr;
    bus.h_we    = we;
    bus.h_lock  = lk;
    bus.h_addr  = ha;
    bus.h_wdata = hd;
    bus.c_req   = cr;
    bus.c_addr  = ca;
    #1;
  endtask

  task automatic model_reset();
    m_lock  = 0;
    m_hlast = 0;
    m_cnt   = 0;
    m_hwait = 0;
    m_cwait = 0;
    exp_hv  = 0;
    exp_cv  = 0;
    exp_hrd = '0;
    exp_crd = '0;
  endtask

  task automatic model_grant(output bit eh, output bit ec);
    bit hr = bus.h_req;
    bit cr = bus.c_req;
    eh = 0;
    ec = 0;
    if (m_lock && bus.h_lock) begin
      if (m_cnt == MB && cr) ec = 1;
      else if (hr) eh = 1;
      else ec = cr;
    end else if (hr && cr) begin
      eh = !m_hlast;
      ec = m_hlast;
    end else begin
      eh = hr;
      ec = cr;
    end
  endtask

  task automatic model_commit(input bit eh, input bit ec);
    int ha = int'(bus.h_addr);
    int ca = int'(bus.c_addr);
    if (bus.h_req && !eh && m_hwait < 65535) m_hwait++;
    if (bus.c_req && !ec && m_cwait < 65535) m_cwait++;
    exp_hv = eh && !bus.h_we;
    exp_cv = ec;
    if (eh && !bus.h_we) exp_hrd = ha < NREG ? ref_mem[ha] : 8'h00;
    if (ec) exp_crd = ca < NREG ? ref_mem[ca] : 8'h00;
    if (eh && bus.h_we && ha < NREG) ref_mem[ha] = bus.h_wdata;
    if (m_lock && bus.h_lock) begin
      if (m_cnt == MB && bus.c_req) m_cnt = 0;
      else if (eh && m_cnt < MB) m_cnt++;
    end else if (eh && bus.h_lock) begin
      m_lock = 1;
      m_cnt  = 1;
    end else begin
      m_lock = 0;
      m_cnt  = 0;
    end
    if (eh) m_hlast = 1;
    else if (ec) m_hlast = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    drive(0, 0, 0, '0, '0, 0, '0);
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
  endtask

  task automatic load_bank();
    rst  = 1;
    load = 1;
    for (int i = 0; i < 128; i++) begin
      load_addr = 7'(i);
      load_data = i >= NREG ? 8'hC3 : (i == 5 ? 8'hA5 : 8'($urandom));
      ref_mem[i] = load_data;
      @(posedge clk);
      #1;
    end
    load = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 1, 1, 7'd3, 8'h11, 1, 7'd4);
    n_chk++;
    if ({bus.h_gnt, bus.c_gnt, bus.bank_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b want 000",
               {bus.h_gnt, bus.c_gnt, bus.bank_we});
    end
    n_chk++;
    if ({bus.bank_addr, bus.bank_wdata} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_bank: got %h/%h want 0/0",
               bus.bank_addr, bus.bank_wdata);
    end
    @(posedge clk);
    #1;
    model_reset();
    n_chk++;
    if ({bus.h_rvalid, bus.c_rvalid, bus.h_rdata, bus.c_rdata} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_rd: got %b%b %h %h want 00 00 00",
               bus.h_rvalid, bus.c_rvalid, bus.h_rdata, bus.c_rdata);
    end
    rst = 0;
  endtask

  task automatic test_single_read();
    bit eh, ec;
    do_reset();
    drive(1, 0, 0, 7'd5, 8'h00, 0, 7'd0);
    model_grant(eh, ec);
    n_chk++;
    if ({bus.h_gnt, bus.c_gnt, bus.bank_addr} !== {2'b10, 7'd5}) begin
      n_fail++;
      $display("FAIL read5_gnt: got %b%b a=%0d want 10 a=5",
               bus.h_gnt, bus.c_gnt, bus.bank_addr);
    end
    model_commit(eh, ec);
    drive(0, 0, 0, '0, '0, 0, '0);
    n_chk++;
    if ({bus.h_rvalid, bus.h_rdata} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL read5_data: got v=%b d=%h want v=1 d=a5",
               bus.h_rvalid, bus.h_rdata);
    end
    model_grant(eh, ec);
    model_commit(eh, ec);
    n_chk++;
    if ({bus.h_rvalid, bus.h_rdata} !== {1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL read5_hold: got v=%b d=%h want v=0 d=a5",
               bus.h_rvalid, bus.h_rdata);
    end
  endtask

  task automatic test_alternate();
    bit eh, ec;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 7'($urandom_range(0, 121)), '0,
            1, 7'($urandom_range(0, 121)));
      model_grant(eh, ec);
      n_chk++;
      if ({bus.h_gnt, bus.c_gnt} !== {i % 2 == 0, i % 2 == 1}) begin
        n_fail++;
        $display("FAIL alt_gnt[%0d]: got %b%b want %b%b", i,
                 bus.h_gnt, bus.c_gnt, i % 2 == 0, i % 2 == 1);
      end
      model_commit(eh, ec);
      n_chk++;
      if ({bus.h_rvalid, bus.c_rvalid, bus.h_rdata, bus.c_rdata}
          !== {exp_hv, exp_cv, exp_hrd, exp_crd}) begin
        n_fail++;
        $display("FAIL alt_rd[%0d]: got %b%b %h %h want %b%b %h %h", i,
                 bus.h_rvalid, bus.c_rvalid, bus.h_rdata, bus.c_rdata,
                 exp_hv, exp_cv, exp_hrd, exp_crd);
      end
    end
  endtask

  task automatic test_burst();
    bit eh, ec;
    int hcnt = 0;
    int ccnt = 0;
    do_reset();
    for (int i = 0; i < MB + 9; i++) begin
      drive(1, 1, 1, 7'(i % NREG), 8'($urandom), 1, 7'($urandom_range(0, 121)));
      model_grant(eh, ec);
      hcnt += int'(bus.h_gnt);
      ccnt += int'(bus.c_gnt);
      n_chk++;
      if ({bus.h_gnt, bus.c_gnt} !== {i != MB, i == MB}) begin
        n_fail++;
        $display("FAIL burst_gnt[%0d]: got %b%b want %b%b", i,
                 bus.h_gnt, bus.c_gnt, i != MB, i == MB);
      end
      model_commit(eh, ec);
    end
    n_chk++;
    if (hcnt != MB + 8 || ccnt != 1) begin
      n_fail++;
      $display("FAIL burst_totals: got h=%0d c=%0d want h=%0d c=1",
               hcnt, ccnt, MB + 8);
    end
    drive(0, 0, 0, '0, '0, 0, '0);
    model_grant(eh, ec);
    model_commit(eh, ec);
  endtask

  task automatic test_out_of_range();
    bit eh, ec;
    do_reset();
    drive(1, 1, 0, 7'd122, 8'hFF, 0, '0);
    model_grant(eh, ec);
    n_chk++;
    if ({bus.h_gnt, bus.bank_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL oor_write: got gnt=%b we=%b want gnt=1 we=0",
               bus.h_gnt, bus.bank_we);
    end
    model_commit(eh, ec);
    drive(1, 0, 0, 7'd122, 8'h00, 0, '0);
    model_grant(eh, ec);
    n_chk++;
    if (bus.h_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_rgnt: got %b want 1", bus.h_gnt);
    end
    model_commit(eh, ec);
    n_chk++;
    if ({bus.h_rvalid, bus.h_rdata} !== 9'h100) begin
      n_fail++;
      $display("FAIL oor_read: got v=%b d=%h want v=1 d=00",
               bus.h_rvalid, bus.h_rdata);
    end
    drive(0, 0, 0, '0, '0, 1, 7'd127);
    model_grant(eh, ec);
    model_commit(eh, ec);
    n_chk++;
    if ({bus.c_rvalid, bus.c_rdata} !== 9'h100) begin
      n_fail++;
      $display("FAIL oor_cread: got v=%b d=%h want v=1 d=00",
               bus.c_rvalid, bus.c_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    bit eh, ec;
    do_reset();
    drive(1, 1, 1, 7'd1, 8'h3C, 1, '0);
    model_grant(eh, ec);
    model_commit(eh, ec);
    drive(0, 0, 1, '0, '0, 1, 7'd10);
    model_grant(eh, ec);
    n_chk++;
    if (bus.c_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_cgnt: got %b want 1", bus.c_gnt);
    end
    model_commit(eh, ec);
    rst = 1;
    drive(1, 0, 1, 7'd2, '0, 1, 7'd11);
    n_chk++;
    if ({bus.c_rvalid, bus.h_gnt, bus.c_gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_rst_rv: got %b want 000",
               {bus.c_rvalid, bus.h_gnt, bus.c_gnt});
    end
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    n_chk++;
    if ({bus.c_rvalid, bus.c_rdata} !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_after_rv: got v=%b d=%h want v=0 d=00",
               bus.c_rvalid, bus.c_rdata);
    end
    drive(1, 0, 0, 7'd2, '0, 1, 7'd11);
    model_grant(eh, ec);
    n_chk++;
    if ({bus.h_gnt, bus.c_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_first_conflict: got %b%b want 10",
               bus.h_gnt, bus.c_gnt);
    end
    model_commit(eh, ec);
  endtask

`ifdef REGBANK_ARB_STATS_EN
  task automatic test_stats();
    bit eh, ec;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 7'(i), 8'($urandom), 1, 7'(i));
      model_grant(eh, ec);
      model_commit(eh, ec);
    end
    drive(0, 0, 0, '0, '0, 0, '0);
    n_chk++;
    if (c_wait_cnt !== 16'd8 || c_wait_cnt !== 16'(m_cwait)) begin
      n_fail++;
      $display("FAIL stats_c: got %0d want 8 (model %0d)",
               c_wait_cnt, m_cwait);
    end
    n_chk++;
    if (h_wait_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_h: got %0d want 2", h_wait_cnt);
    end
  endtask
`endif

  task automatic test_random();
    bit eh, ec;
    bit lk = 0;
    bit e_we;
    logic [6:0] e_addr;
    logic [7:0] e_wd;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) lk = !lk;
      drive($urandom_range(0, 9) < 7, 1'($urandom), lk,
            7'($urandom), 8'($urandom),
            $urandom_range(0, 9) < 6, 7'($urandom));
      if ($urandom_range(0, 79) == 0) begin
        rst = 1;
        #1;
        n_chk++;
        if ({bus.h_gnt, bus.c_gnt, bus.bank_we} !== 3'b000) begin
          n_fail++;
          $display("FAIL rnd_rst_gnt[%0d]: got %b want 000", i,
                   {bus.h_gnt, bus.c_gnt, bus.bank_we});
        end
        @(posedge clk);
        #1;
        model_reset();
        rst = 0;
      end else begin
        model_grant(eh, ec);
        e_we   = eh && bus.h_we && int'(bus.h_addr) < NREG;
        e_addr = eh ? bus.h_addr : (ec ? bus.c_addr : 7'd0);
        e_wd   = eh ? bus.h_wdata : 8'd0;
        n_chk++;
        if ({bus.h_gnt, bus.c_gnt, bus.bank_we, bus.bank_addr, bus.bank_wdata}
            !== {eh, ec, e_we, e_addr, e_wd}) begin
          n_fail++;
          $display("FAIL rnd_gnt[%0d]: got %b%b%b a=%h d=%h want %b%b%b a=%h d=%h",
                   i, bus.h_gnt, bus.c_gnt, bus.bank_we, bus.bank_addr,
                   bus.bank_wdata, eh, ec, e_we, e_addr, e_wd);
        end
        model_commit(eh, ec);
        n_chk++;
        if ({bus.h_rvalid, bus.c_rvalid, bus.h_rdata, bus.c_rdata}
            !== {exp_hv, exp_cv, exp_hrd, exp_crd}) begin
          n_fail++;
          $display("FAIL rnd_rd[%0d]: got %b%b %h %h want %b%b %h %h", i,
                   bus.h_rvalid, bus.c_rvalid, bus.h_rdata, bus.c_rdata,
                   exp_hv, exp_cv, exp_hrd, exp_crd);
        end
      end
    end
`ifdef REGBANK_ARB_STATS_EN
    n_chk++;
    if ({h_wait_cnt, c_wait_cnt} !== {16'(m_hwait), 16'(m_cwait)}) begin
      n_fail++;
      $display("FAIL rnd_stats: got h=%0d c=%0d want h=%0d c=%0d",
               h_wait_cnt, c_wait_cnt, m_hwait, m_cwait);
    end
`endif
  endtask

  initial begin
    drive(0, 0, 0, '0, '0, 0, '0);
    load_bank();
    test_reset();
    test_single_read();
    test_alternate();
    test_burst();
    test_out_of_range();
    test_reset_mid_read();
`ifdef REGBANK_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
